// File: rtl/dm_pkg.sv
// Shared encodings and helpers for the data-memory responder.
package dm_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_BAD  = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_BUSY = 2'b01,
    S_DONE = 2'b10
  } state_e;

  // Natural alignment check; the reserved size code is always rejected.
  function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = (lane != 2'b00);
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Little-endian lane steering: byte enables and replicated data for stores,
// lane extraction with sign/zero extension for loads.
module dm_lane_align
  import dm_pkg::*;
(
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [1:0]  lane,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic [3:0]  be,
  output logic [31:0] wword,
  output logic [31:0] rdata
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Store path: pick the written lanes and replicate the data across the word.
  always_comb begin
    be    = 4'b0000;
    wword = 32'h0000_0000;
    case (size)
      SZ_BYTE: begin
        be    = 4'b0001 << lane;
        wword = {4{wdata[7:0]}};
      end
      SZ_HALF: begin
        be    = lane[1] ? 4'b1100 : 4'b0011;
        wword = {2{wdata[15:0]}};
      end
      SZ_WORD: begin
        be    = 4'b1111;
        wword = wdata;
      end
      default: begin
        be    = 4'b0000;
        wword = 32'h0000_0000;
      end
    endcase
  end

  // Load path: extract the addressed lane and extend it to 32 bits.
  always_comb begin
    byte_s = 8'h00;
    half_s = lane[1] ? rword[31:16] : rword[15:0];
    case (lane)
      2'b00:   byte_s = rword[7:0];
      2'b01:   byte_s = rword[15:8];
      2'b10:   byte_s = rword[23:16];
      2'b11:   byte_s = rword[31:24];
      default: byte_s = 8'h00;
    endcase
    case (size)
      SZ_BYTE: rdata = {{24{sext & byte_s[7]}}, byte_s};
      SZ_HALF: rdata = {{16{sext & half_s[15]}}, half_s};
      SZ_WORD: rdata = rword;
      default: rdata = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/dm_responder.sv
// Data-memory responder: latches a held request, waits LATENCY cycles,
// performs the aligned access on the word array and pulses ack for one cycle.
module dm_responder
  import dm_pkg::*;
#(
  parameter int ADDR_W  = 12,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        err
);

  localparam int         DEPTH = 2 ** (ADDR_W - 2);
  localparam logic [3:0] LAT   = 4'(LATENCY);

  logic [31:0] dm [0:DEPTH-1];

  state_e              state_r;
  logic [3:0]          cnt_r;
  logic                we_r;
  logic [1:0]          size_r;
  logic                sext_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [31:0]         wdata_r;
  logic                mis_r;
  logic                ack_r;
  logic                err_r;
  logic [31:0]         rdata_r;

  logic [3:0]          be_s;
  logic [31:0]         wword_s;
  logic [31:0]         rword_s;
  logic [31:0]         rdext_s;
  logic                access_s;
  logic                wr_en_s;
  logic                unused_addr_s;

  assign unused_addr_s = ^addr[31:ADDR_W];
  assign rword_s       = dm[addr_r[ADDR_W-1:2]];

  dm_lane_align u_align (
    .size  (size_r),
    .sext  (sext_r),
    .lane  (addr_r[1:0]),
    .wdata (wdata_r),
    .rword (rword_s),
    .be    (be_s),
    .wword (wword_s),
    .rdata (rdext_s)
  );

  // Access strobe: last wait edge of a well-formed request; reset blocks the write.
  always_comb begin
    access_s = 1'b0;
    if ((state_r == S_BUSY) && (cnt_r == 4'd0) && !mis_r) begin
      access_s = 1'b1;
    end else begin
      access_s = 1'b0;
    end
    wr_en_s = access_s && we_r && reset;
  end

  // Word array with per-lane write enables; contents survive reset.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      for (int i = 0; i < 4; i++) begin
        if (be_s[i]) begin
          dm[addr_r[ADDR_W-1:2]][8*i +: 8] <= wword_s[8*i +: 8];
        end
      end
    end
  end

  // Control FSM, wait counter, request latches and registered responses.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= S_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      size_r  <= 2'b00;
      sext_r  <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 32'h0000_0000;
      mis_r   <= 1'b0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
      rdata_r <= 32'h0000_0000;
    end else begin
      case (state_r)
        S_IDLE: begin
          ack_r <= 1'b0;
          err_r <= 1'b0;
          if (req) begin
            we_r    <= we;
            size_r  <= size;
            sext_r  <= sext;
            addr_r  <= addr[ADDR_W-1:0];
            wdata_r <= wdata;
            // A rejected request still spends one wait edge before responding.
            mis_r   <= misaligned(size, addr[1:0]);
            cnt_r   <= misaligned(size, addr[1:0]) ? 4'd0 : LAT;
            state_r <= S_BUSY;
          end
        end
        S_BUSY: begin
          if (cnt_r == 4'd0) begin
            state_r <= S_DONE;
            ack_r   <= 1'b1;
            err_r   <= mis_r;
            if (access_s && !we_r) begin
              rdata_r <= rdext_s;
            end
          end else begin
            cnt_r <= cnt_r - 4'd1;
          end
        end
        S_DONE: begin
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          ack_r   <= 1'b0;
          err_r   <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

  assign ack   = ack_r;
  assign err   = err_r;
  assign rdata = rdata_r;

endmodule
